// File: rtl/rot_pkg.sv
// Shared constants for the root-of-trust op scheduler: opcodes, engine indices,
// status word layout and the sequencer state encoding.
package rot_pkg;

   localparam int unsigned OP_NOP        = 'h00;
   localparam int unsigned OP_FSM        = 'h01;
   localparam int unsigned OP_TRNG_GEN   = 'h02;
   localparam int unsigned OP_AES_ENC    = 'h03;
   localparam int unsigned OP_PUF_GEN    = 'h04;
   localparam int unsigned OP_CLR_STATUS = 'h0F;

   typedef logic [1:0] eng_idx_t;

   localparam eng_idx_t ENG_FSM  = 2'd0;
   localparam eng_idx_t ENG_TRNG = 2'd1;
   localparam eng_idx_t ENG_AES  = 2'd2;
   localparam eng_idx_t ENG_PUF  = 2'd3;

   localparam int unsigned ST_BUSY       = 0;
   localparam int unsigned ST_FSM_BUSY   = 1;
   localparam int unsigned ST_TRNG_BUSY  = 2;
   localparam int unsigned ST_AES_BUSY   = 3;
   localparam int unsigned ST_PUF_BUSY   = 4;
   localparam int unsigned ST_FULL       = 5;
   localparam int unsigned ST_FLAG_LSB   = 26;
   localparam int unsigned ST_CFG        = 26;
   localparam int unsigned ST_AES_DONE   = 27;
   localparam int unsigned ST_PUF_DONE   = 28;
   localparam int unsigned ST_TRNG_VALID = 29;
   localparam int unsigned ST_ERR        = 30;
   localparam int unsigned ST_TIMEOUT    = 31;

   // Masks over the sticky field status[31:26].
   localparam logic [5:0] FLAG_CFG        = 6'b000001;
   localparam logic [5:0] FLAG_AES_DONE   = 6'b000010;
   localparam logic [5:0] FLAG_PUF_DONE   = 6'b000100;
   localparam logic [5:0] FLAG_TRNG_VALID = 6'b001000;
   localparam logic [5:0] FLAG_ERR        = 6'b010000;
   localparam logic [5:0] FLAG_TIMEOUT    = 6'b100000;

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StDispatch,
      StWait,
      StAbort
   } state_e;

   function automatic logic [5:0] done_flag(eng_idx_t eng);
      logic [5:0] mask;
      unique case (eng)
         ENG_FSM:  mask = FLAG_CFG;
         ENG_TRNG: mask = FLAG_TRNG_VALID;
         ENG_AES:  mask = FLAG_AES_DONE;
         default:  mask = FLAG_PUF_DONE;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/rot_op_fifo.sv
// Synchronous opcode FIFO. A push on a full FIFO is accepted only when a pop
// frees a slot in the same cycle.
module rot_op_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wptr_q, rptr_q;
   logic [PtrW:0]    count_q;
   logic             push_en, pop_en;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (PtrW+1)'(DEPTH));
   assign pop_en  = pop && !empty;
   assign push_en = push && (!full || pop_en);
   assign rdata   = mem_q[rptr_q];
   assign count   = count_q;

   always_ff @(posedge clk) begin
      if (push_en) begin
         mem_q[wptr_q] <= wdata;
      end
   end

   // Depth is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_en) wptr_q <= wptr_q + PtrW'(1);
         if (pop_en)  rptr_q <= rptr_q + PtrW'(1);
         if (push_en && !pop_en) begin
            count_q <= count_q + (PtrW+1)'(1);
         end else if (pop_en && !push_en) begin
            count_q <= count_q - (PtrW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/rot_op_scheduler.sv
// Root-of-trust command sequencer: queues CPU opcodes, dispatches them to the
// FSM/TRNG/AES/PUF engines with a start/done handshake and a watchdog.
module rot_op_scheduler
   import rot_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned OPW            = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           op_we,
   input  logic [OPW-1:0] op_code,
   output logic [3:0]     eng_start,
   input  logic [3:0]     eng_done,
   output logic           eng_abort,
   output logic [31:0]    status_o
);

   localparam int unsigned   CntW     = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned   WdW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WdW-1:0] WdLast  = WdW'(TIMEOUT_CYCLES - 1);
   localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

   state_e          state_q, state_d;
   logic [OPW-1:0]  op_q, op_d;
   eng_idx_t        eng_q, eng_d;
   logic [WdW-1:0]  wdog_q, wdog_d;
   logic [31:0]     status_q, status_d;

   logic            fifo_full, fifo_empty;
   logic [CntW-1:0] fifo_count, cnt_d;
   logic [OPW-1:0]  fifo_rdata;

   logic            wr_clr, push_req, push, pop, drop;
   logic            op_legal, op_needs_cfg;
   eng_idx_t        op_eng;
   logic            set_err, set_to, set_done, clr_done;
   logic [5:0]      flags;

   assign wr_clr   = op_we && (op_code == OPW'(OP_CLR_STATUS));
   assign push_req = op_we && (op_code != OPW'(OP_NOP)) && !wr_clr;
   assign pop      = (state_q == StIdle) && !fifo_empty;
   assign push     = push_req && (!fifo_full || pop);
   assign drop     = push_req && !push;

   rot_op_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (OPW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (op_code),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Occupancy after this edge, so the registered status word is not a cycle stale.
   always_comb begin
      cnt_d = fifo_count;
      if (push && !pop) begin
         cnt_d = fifo_count + CntW'(1);
      end else if (pop && !push) begin
         cnt_d = fifo_count - CntW'(1);
      end
   end

   always_comb begin
      op_legal     = 1'b1;
      op_needs_cfg = 1'b0;
      op_eng       = ENG_FSM;
      if (op_q == OPW'(OP_FSM)) begin
         op_eng = ENG_FSM;
      end else if (op_q == OPW'(OP_TRNG_GEN)) begin
         op_eng = ENG_TRNG;
      end else if (op_q == OPW'(OP_AES_ENC)) begin
         op_eng       = ENG_AES;
         op_needs_cfg = 1'b1;
      end else if (op_q == OPW'(OP_PUF_GEN)) begin
         op_eng       = ENG_PUF;
         op_needs_cfg = 1'b1;
      end else begin
         op_legal = 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      eng_d     = eng_q;
      wdog_d    = wdog_q;
      set_err   = 1'b0;
      set_to    = 1'b0;
      set_done  = 1'b0;
      clr_done  = 1'b0;
      eng_start = 4'b0000;
      eng_abort = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               op_d    = fifo_rdata;
               state_d = StCheck;
            end
         end
         StCheck: begin
            if (!op_legal || (op_needs_cfg && !status_q[ST_CFG])) begin
               set_err = 1'b1;
               state_d = StIdle;
            end else begin
               eng_d   = op_eng;
               state_d = StDispatch;
            end
         end
         StDispatch: begin
            eng_start = 4'b0001 << eng_q;
            clr_done  = 1'b1;
            wdog_d    = '0;
            state_d   = StWait;
         end
         StWait: begin
            wdog_d = wdog_q + WdW'(1);
            if (eng_done[eng_q]) begin
               set_done = 1'b1;
               state_d  = StIdle;
            end else if (wdog_q == WdLast) begin
               state_d = StAbort;
            end
         end
         StAbort: begin
            eng_abort = 1'b1;
            set_to    = 1'b1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Clear first so that a flag set in the same cycle as CLR_STATUS survives.
   always_comb begin
      flags = status_q[ST_TIMEOUT:ST_FLAG_LSB];
      if (wr_clr)            flags = 6'b000000;
      if (clr_done)          flags = flags & ~done_flag(eng_q);
      if (set_done)          flags = flags | done_flag(eng_q);
      if (set_err || drop)   flags = flags | FLAG_ERR;
      if (set_to)            flags = flags | FLAG_TIMEOUT;

      status_d = '0;
      status_d[ST_TIMEOUT:ST_FLAG_LSB] = flags;
      status_d[ST_BUSY] = (state_d != StIdle) || (cnt_d != '0);
      if (state_d == StDispatch || state_d == StWait) begin
         status_d[ST_PUF_BUSY:ST_FSM_BUSY] = 4'b0001 << eng_d;
      end
      status_d[ST_FULL] = (cnt_d == CntFull);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         op_q     <= '0;
         eng_q    <= ENG_FSM;
         wdog_q   <= '0;
         status_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         eng_q    <= eng_d;
         wdog_q   <= wdog_d;
         status_q <= status_d;
      end
   end

   assign status_o = status_q;

endmodule

// File: tb/tb_rot_op_scheduler.sv
// Self-checking bench for rot_op_scheduler: start pulses are checked against a
// scoreboard of expected one-hot starts; a second instance covers the watchdog.
module tb_rot_op_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        op_we = 1'b0;
   logic [7:0]  op_code = 8'h00;
   logic [3:0]  eng_done = 4'b0000;
   logic [3:0]  eng_start;
   logic        eng_abort;
   logic [31:0] status;

   logic        t_we = 1'b0;
   logic [7:0]  t_code = 8'h00;
   logic [3:0]  t_done = 4'b0000;
   logic [3:0]  t_start;
   logic        t_abort;
   logic [31:0] t_status;

   int          errors = 0;
   int          checks = 0;
   int          n_start = 0;
   int          n_abort = 0;
   logic [3:0]  exp_q [$];
   logic [3:0]  mon_exp;

   always #5 clk = ~clk;

   rot_op_scheduler #(
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (1024),
      .OPW            (8)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .op_we     (op_we),
      .op_code   (op_code),
      .eng_start (eng_start),
      .eng_done  (eng_done),
      .eng_abort (eng_abort),
      .status_o  (status)
   );

   rot_op_scheduler #(
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (16),
      .OPW            (8)
   ) u_dut_to (
      .clk       (clk),
      .rst       (rst),
      .op_we     (t_we),
      .op_code   (t_code),
      .eng_start (t_start),
      .eng_done  (t_done),
      .eng_abort (t_abort),
      .status_o  (t_status)
   );

   // Scoreboard: every start pulse must match the oldest expected start.
   always @(negedge clk) begin
      if (eng_abort) n_abort++;
      if (eng_start != 4'b0000) begin
         n_start++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL start_unexpected: got %b, no start expected", eng_start);
         end else begin
            mon_exp = exp_q.pop_front();
            if (eng_start !== mon_exp) begin
               errors++;
               $display("FAIL start_value: got %b, expected %b", eng_start, mon_exp);
            end
         end
      end
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      op_we    = 1'b0;
      eng_done = 4'b0000;
      t_we     = 1'b0;
      t_done   = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic write_op(input logic [7:0] code);
      op_we   = 1'b1;
      op_code = code;
      sync();
      op_we   = 1'b0;
   endtask

   task automatic wait_start(output logic [3:0] seen);
      seen = 4'b0000;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (eng_start != 4'b0000) begin
            seen = eng_start;
            break;
         end
      end
      checks++;
      if (seen == 4'b0000) begin
         errors++;
         $display("FAIL start_timeout: got no start in 64 cycles, expected one");
      end
   endtask

   task automatic pulse_done(input logic [3:0] k, input int delay);
      repeat (delay) @(posedge clk);
      #1;
      eng_done = k;
      sync();
      eng_done = 4'b0000;
   endtask

   task automatic test_reset();
      #2;
      checks += 4;
      if (status !== 32'h0) begin
         errors++; $display("FAIL reset_status: got %h, expected 0", status);
      end
      if (eng_start !== 4'b0000) begin
         errors++; $display("FAIL reset_start: got %b, expected 0000", eng_start);
      end
      if (eng_abort !== 1'b0) begin
         errors++; $display("FAIL reset_abort: got %b, expected 0", eng_abort);
      end
      if (t_status !== 32'h0) begin
         errors++; $display("FAIL reset_status_to: got %h, expected 0", t_status);
      end
      @(posedge clk);
      sync();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (status !== 32'h0) begin
         errors++; $display("FAIL idle_status: got %h, expected 0", status);
      end
      sync();
   endtask

   task automatic test_fsm_config();
      int s0;
      logic [3:0] seen;
      s0 = n_start;
      exp_q.push_back(4'b0001);
      write_op(8'h01);
      wait_start(seen);
      checks++;
      if (status[1] !== 1'b1) begin
         errors++; $display("FAIL fsm_busy: got %b, expected 1", status[1]);
      end
      pulse_done(4'b0001, 5);
      @(negedge clk);
      checks += 3;
      if (status[26] !== 1'b1) begin
         errors++; $display("FAIL fsm_cfg: got %b, expected 1", status[26]);
      end
      if (status[0] !== 1'b0) begin
         errors++; $display("FAIL fsm_idle: got %b, expected 0", status[0]);
      end
      if (status[31:26] !== 6'b000001) begin
         errors++; $display("FAIL fsm_flags: got %b, expected 000001", status[31:26]);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (n_start - s0 !== 1) begin
         errors++; $display("FAIL fsm_start_count: got %0d, expected 1", n_start - s0);
      end
      sync();
   endtask

   task automatic test_trng();
      int bad;
      logic [3:0] seen;
      bad = 0;
      exp_q.push_back(4'b0010);
      write_op(8'h02);
      wait_start(seen);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (status[2] !== 1'b1) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL trng_busy: got %0d cycles low, expected 0", bad);
      end
      pulse_done(4'b0010, 1);
      @(negedge clk);
      checks += 2;
      if (status[31:26] !== 6'b001001) begin
         errors++; $display("FAIL trng_flags: got %b, expected 001001", status[31:26]);
      end
      if (status[5:0] !== 6'b000000) begin
         errors++; $display("FAIL trng_low: got %b, expected 000000", status[5:0]);
      end
      sync();
   endtask

   task automatic test_aes_unconfigured();
      int s0;
      bit found;
      do_reset();
      s0    = n_start;
      found = 1'b0;
      write_op(8'h03);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (status[0] === 1'b0) begin
            found = 1'b1;
            break;
         end
      end
      checks += 2;
      if (!found) begin
         errors++; $display("FAIL aes_idle: got busy after 3 cycles, expected idle");
      end
      if (status[30] !== 1'b1) begin
         errors++; $display("FAIL aes_err: got %b, expected 1", status[30]);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (n_start !== s0) begin
         errors++; $display("FAIL aes_no_start: got %0d starts, expected 0", n_start - s0);
      end
      sync();
   endtask

   task automatic test_back_to_back();
      int s0;
      logic [3:0] seen;
      do_reset();
      exp_q.push_back(4'b0001);
      write_op(8'h01);
      wait_start(seen);
      sync();
      s0 = n_start;
      exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0010);
      write_op(8'h01);
      write_op(8'h02);
      write_op(8'h02);
      write_op(8'h02);
      checks += 2;
      if (status[5] !== 1'b1) begin
         errors++; $display("FAIL b2b_full: got %b, expected 1", status[5]);
      end
      if (status[30] !== 1'b0) begin
         errors++; $display("FAIL b2b_err_early: got %b, expected 0", status[30]);
      end
      write_op(8'h02);
      checks += 2;
      if (status[30] !== 1'b1) begin
         errors++; $display("FAIL b2b_drop_err: got %b, expected 1", status[30]);
      end
      if (status[5] !== 1'b1) begin
         errors++; $display("FAIL b2b_still_full: got %b, expected 1", status[5]);
      end
      pulse_done(4'b0001, 1);
      for (int i = 0; i < 4; i++) begin
         wait_start(seen);
         pulse_done(seen, 2);
      end
      repeat (10) @(negedge clk);
      checks += 3;
      if (n_start - s0 !== 4) begin
         errors++; $display("FAIL b2b_starts: got %0d, expected 4", n_start - s0);
      end
      if (exp_q.size() !== 0) begin
         errors++; $display("FAIL b2b_pending: got %0d left, expected 0", exp_q.size());
      end
      if (status[0] !== 1'b0) begin
         errors++; $display("FAIL b2b_idle: got %b, expected 0", status[0]);
      end
      sync();
   endtask

   task automatic test_timeout();
      int cnt;
      bit seen;
      do_reset();
      t_we   = 1'b1;
      t_code = 8'h02;
      sync();
      sync();
      t_we   = 1'b0;
      seen   = 1'b0;
      for (int i = 0; i < 64 && !seen; i++) begin
         @(negedge clk);
         if (t_start != 4'b0000) seen = 1'b1;
      end
      checks++;
      if (t_start !== 4'b0010) begin
         errors++; $display("FAIL to_start1: got %b, expected 0010", t_start);
      end
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         cnt++;
         if (t_abort) break;
      end
      checks++;
      if (cnt !== 17) begin
         errors++; $display("FAIL to_abort_cycle: got %0d, expected 17", cnt);
      end
      @(negedge clk);
      checks += 3;
      if (t_abort !== 1'b0) begin
         errors++; $display("FAIL to_abort_width: got %b, expected 0", t_abort);
      end
      if (t_status[31] !== 1'b1) begin
         errors++; $display("FAIL to_flag: got %b, expected 1", t_status[31]);
      end
      if (t_status[29] !== 1'b0) begin
         errors++; $display("FAIL to_trng_valid: got %b, expected 0", t_status[29]);
      end
      seen = 1'b0;
      for (int i = 0; i < 64 && !seen; i++) begin
         @(negedge clk);
         if (t_start != 4'b0000) seen = 1'b1;
      end
      checks++;
      if (t_start !== 4'b0010) begin
         errors++; $display("FAIL to_start2: got %b, expected 0010", t_start);
      end
      sync();
      t_done = 4'b0010;
      sync();
      t_done = 4'b0000;
      @(negedge clk);
      checks += 2;
      if (t_status[29] !== 1'b1) begin
         errors++; $display("FAIL to_next_done: got %b, expected 1", t_status[29]);
      end
      if (t_status[31] !== 1'b1) begin
         errors++; $display("FAIL to_sticky: got %b, expected 1", t_status[31]);
      end
      sync();
   endtask

   task automatic test_clr_and_reset();
      int a0;
      logic [3:0] seen;
      exp_q.push_back(4'b0001);
      write_op(8'h01);
      wait_start(seen);
      pulse_done(4'b0001, 2);
      exp_q.push_back(4'b0010);
      write_op(8'h02);
      wait_start(seen);
      pulse_done(4'b0010, 2);
      checks++;
      if (status[31:26] !== 6'b001001) begin
         errors++; $display("FAIL clr_pre: got %b, expected 001001", status[31:26]);
      end
      write_op(8'h0F);
      checks += 2;
      if (status[31:26] !== 6'b000000) begin
         errors++; $display("FAIL clr_flags: got %b, expected 000000", status[31:26]);
      end
      if (status[0] !== 1'b0) begin
         errors++; $display("FAIL clr_not_queued: got %b, expected 0", status[0]);
      end
      exp_q.push_back(4'b0001);
      write_op(8'h01);
      wait_start(seen);
      sync();
      a0 = n_abort;
      #2;
      rst = 1'b1;
      #1;
      checks += 3;
      if (status !== 32'h0) begin
         errors++; $display("FAIL rst_status: got %h, expected 0", status);
      end
      if (eng_start !== 4'b0000) begin
         errors++; $display("FAIL rst_start: got %b, expected 0000", eng_start);
      end
      if (eng_abort !== 1'b0) begin
         errors++; $display("FAIL rst_abort: got %b, expected 0", eng_abort);
      end
      repeat (3) @(negedge clk);
      checks += 2;
      if (n_abort !== a0) begin
         errors++; $display("FAIL rst_no_abort: got %0d, expected %0d", n_abort, a0);
      end
      if (n_abort !== 0) begin
         errors++; $display("FAIL main_aborts: got %0d, expected 0", n_abort);
      end
      sync();
      rst = 1'b0;
      sync();
   endtask

   initial begin
      test_reset();
      test_fsm_config();
      test_trng();
      test_aes_unconfigured();
      test_back_to_back();
      test_timeout();
      do_reset();
      test_clr_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench still running at 200000, expected finish");
      $fatal(1, "simulation time limit");
   end

endmodule
